// File: rtl/xtea_codec.sv
// rtl/xtea_codec.sv - multi-lane iterative XTEA codec, one half-round per clock
// Define XTEA_CODEC_DECRYPT_EN to build the decipher datapath; otherwise every job enciphers.
module xtea_codec #(
  parameter int          LANES  = 2,
  parameter int          ROUNDS = 32,
  parameter logic [31:0] DELTA  = 32'h9E3779B9
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic                decrypt,
  input  logic [127:0]        key_in,
  input  logic [64*LANES-1:0] data_in,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [64*LANES-1:0] data_out
);
  typedef enum logic [1:0] {IDLE, RUN_Y, RUN_Z, DONE} state_t;

  state_t       state;
  logic [127:0] key_r;
  logic [31:0]  sum;
  logic [7:0]   rnd;
  logic         live;
  logic [31:0]  y_r [LANES];
  logic [31:0]  z_r [LANES];
  logic         accept;

`ifdef XTEA_CODEC_DECRYPT_EN
  localparam logic [31:0] SUM_DEC = 32'(DELTA * 32'(ROUNDS));
  logic mode_r;
`else
  logic unused_decrypt;
  assign unused_decrypt = decrypt;
`endif

  function automatic logic [31:0] mix(input logic [31:0] v);
    return ((v << 4) ^ (v >> 5)) + v;
  endfunction

  function automatic logic [31:0] kword(input logic [1:0] i);
    return key_r[32*i +: 32];
  endfunction

  // live holds in_ready low until the first clock after reset release
  assign in_ready = live && (state == IDLE || (state == DONE && out_valid && out_ready));
  assign accept   = in_valid && in_ready;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      key_r     <= '0;
      sum       <= '0;
      rnd       <= '0;
      live      <= 1'b0;
      out_valid <= 1'b0;
      data_out  <= '0;
`ifdef XTEA_CODEC_DECRYPT_EN
      mode_r    <= 1'b0;
`endif
      for (int n = 0; n < LANES; n++) begin
        y_r[n] <= '0;
        z_r[n] <= '0;
      end
    end else begin
      live <= 1'b1;
      if (accept) begin
        key_r     <= key_in;
        rnd       <= '0;
        out_valid <= 1'b0;
        state     <= RUN_Y;
`ifdef XTEA_CODEC_DECRYPT_EN
        mode_r    <= decrypt;
        sum       <= decrypt ? SUM_DEC : 32'd0;
`else
        sum       <= '0;
`endif
        for (int n = 0; n < LANES; n++) begin
          y_r[n] <= data_in[64*n +: 32];
          z_r[n] <= data_in[64*n+32 +: 32];
        end
      end else begin
        case (state)
          RUN_Y: begin
            for (int n = 0; n < LANES; n++) begin
`ifdef XTEA_CODEC_DECRYPT_EN
              if (mode_r) z_r[n] <= z_r[n] - (mix(y_r[n]) ^ (sum + kword(sum[12:11])));
              else
`endif
              y_r[n] <= y_r[n] + (mix(z_r[n]) ^ (sum + kword(sum[1:0])));
            end
`ifdef XTEA_CODEC_DECRYPT_EN
            if (mode_r) sum <= sum - DELTA;
            else
`endif
            sum <= sum + DELTA;
            state <= RUN_Z;
          end
          RUN_Z: begin
            for (int n = 0; n < LANES; n++) begin
`ifdef XTEA_CODEC_DECRYPT_EN
              if (mode_r) y_r[n] <= y_r[n] - (mix(z_r[n]) ^ (sum + kword(sum[1:0])));
              else
`endif
              z_r[n] <= z_r[n] + (mix(y_r[n]) ^ (sum + kword(sum[12:11])));
            end
            rnd   <= rnd + 8'd1;
            state <= ((rnd + 8'd1) == 8'(ROUNDS)) ? DONE : RUN_Y;
          end
          DONE: begin
            // first DONE cycle registers the result; afterwards wait for the consumer
            if (!out_valid) begin
              out_valid <= 1'b1;
              for (int n = 0; n < LANES; n++) data_out[64*n +: 64] <= {z_r[n], y_r[n]};
            end else if (out_ready) begin
              out_valid <= 1'b0;
              state     <= IDLE;
            end
          end
          default: ;
        endcase
      end
    end
  end
endmodule

// File: doc/xtea_codec.md
XTEA_CODEC -- requirements
Module: xtea_codec

Interface
REQ-001 Parameter LANES, default 2, number of independent 64-bit blocks processed in parallel under one key (legal 1..8).
REQ-002 Parameter ROUNDS, default 32, XTEA cycles per block (legal 1..255).
REQ-003 Parameter DELTA, default 32'h9E3779B9, key-schedule constant.
REQ-004 clock  input  1  sole clock; all state updates on rising edge.
REQ-005 reset  input  1  asynchronous, active-low reset.
REQ-006 in_valid  input  1  data_in/key_in/decrypt valid.
REQ-007 in_ready  output  1  block can accept a new job this cycle.
REQ-008 decrypt  input  1  1 = decipher, 0 = encipher; sampled on accept.
REQ-009 key_in  input  128  key; word k = key_in[32k+31:32k]; sampled on accept.
REQ-010 data_in  input  64*LANES  lane n: y = bits [64n+31:64n], z = bits [64n+63:64n+32].
REQ-011 out_valid  output  1  data_out holds a finished result.
REQ-012 out_ready  input  1  consumer accepts data_out.
REQ-013 data_out  output  64*LANES  result, same lane/word layout as data_in.

Function
REQ-014 States: IDLE, RUN_Y, RUN_Z, DONE.
REQ-015 in_ready = 1 in IDLE, or in DONE while out_ready = 1; 0 otherwise.
REQ-016 Accept = in_valid & in_ready; on accept: latch key, mode, all lane y/z, clear round counter, go to RUN_Y.
REQ-017 Encrypt init: sum = 0; decrypt init: sum = DELTA*ROUNDS, truncated to 32 bits.
REQ-018 Encrypt RUN_Y, every lane: y += (((z<<4)^(z>>5))+z) ^ (sum + key[sum[1:0]]); sum += DELTA; go to RUN_Z.
REQ-019 Encrypt RUN_Z, every lane: z += (((y<<4)^(y>>5))+y) ^ (sum + key[sum[12:11]]), using the updated y and sum; round counter +1.
REQ-020 Decrypt RUN_Y, every lane: z -= (((y<<4)^(y>>5))+y) ^ (sum + key[sum[12:11]]); sum -= DELTA; go to RUN_Z.
REQ-021 Decrypt RUN_Z, every lane: y -= (((z<<4)^(z>>5))+z) ^ (sum + key[sum[1:0]]), using the updated z and sum; round counter +1.
REQ-022 All arithmetic is modulo 2^32; shifts are logical.
REQ-023 After RUN_Z, if round counter = ROUNDS, go to DONE; otherwise go to RUN_Y.
REQ-024 On entry to DONE: data_out loaded from the lane registers; out_valid = 1.
REQ-025 Latency: exactly 2*ROUNDS+1 cycles from the accept edge to the first cycle with out_valid = 1.
REQ-026 In DONE: data_out and out_valid hold stable until out_ready = 1.
REQ-027 DONE with out_ready = 1 and no accept: next state IDLE; out_valid drops next cycle; data_out retains its value.
REQ-028 DONE with out_ready = 1 and in_valid = 1: the result is consumed and the new job is accepted in the same cycle; next state RUN_Y; no idle bubble.
REQ-029 in_valid and input changes during RUN_Y/RUN_Z are ignored; there is no abort.
REQ-030 Round counter is 8 bits and never wraps (ROUNDS <= 255).

Reset
REQ-031 reset low forces IDLE immediately, independent of clock.
REQ-032 reset low clears out_valid, data_out, lane registers, key/mode latches, sum and round counter to 0.
REQ-033 reset low forces in_ready to 0 while asserted; in_ready = 1 on the first clock after release.
REQ-034 Reset during RUN_Y/RUN_Z discards the job; no out_valid is produced for it.

Configuration
REQ-035 Macro XTEA_CODEC_DECRYPT_EN defined: decrypt input is honoured per REQ-017/020/021.
REQ-036 Macro XTEA_CODEC_DECRYPT_EN undefined: decrypt input is ignored; only encrypt datapath is synthesised; every job runs in encrypt mode.

Verification
REQ-037 LANES=1, ROUNDS=32, key_in=128'h0C0D0E0F_08090A0B_04050607_00010203, encrypt y=32'h41424344 z=32'h45464748 -> y=32'h497DF3D0 z=32'h72612CB5, out_valid 65 cycles after accept.
REQ-038 LANES=2, ROUNDS=32, key 0: lane0 = the REQ-037 vector, lane1 = all-zero data, with key and lane0 data from REQ-037 -> lane0 output matches REQ-037, unaffected by lane1.
REQ-039 DECRYPT_EN defined: decrypt the REQ-037 ciphertext with the same key -> y=32'h41424344, z=32'h45464748; random key/data encrypt-then-decrypt round-trip returns the original for 100 jobs.
REQ-040 Hold out_ready=0 for 10 cycles in DONE -> data_out and out_valid stable, in_ready=0; then out_ready=1 with in_valid=1 -> back-to-back accept and next result exactly 65 cycles later.
REQ-041 Assert reset low at round 10 of a job -> out_valid=0 and data_out=0 immediately; after release, a fresh REQ-037 job yields the correct result.
REQ-042 ROUNDS=1 build, or DECRYPT_EN undefined with decrypt=1 -> latency 3 cycles, or output equals the encrypt result, respectively.
